// File: rtl/abc_add_pkg.sv
// Shared widths, alignment shifts, result record and the fixed-point adder
// for the abc_add_arb shared three-operand adder.
package abc_add_pkg;

  localparam int A_W      = 5;   // 2's complement 2.3
  localparam int B_W      = 5;   // 2's complement 4.1
  localparam int C_W      = 5;   // unsigned 5.0
  localparam int SUM_W    = 10;  // 2's complement 7.3
  localparam int B_SHL    = 2;
  localparam int C_SHL    = 3;
  localparam int MAX_TAGW = 3;

  typedef struct packed {
    logic [SUM_W-1:0]    sum;
    logic [MAX_TAGW-1:0] tag;
  } abc_res_t;

  // Align all operands to 3 fractional bits; the range never overflows 7.3.
  function automatic logic [SUM_W-1:0] abc_sum(input logic [A_W-1:0] a,
                                               input logic [B_W-1:0] b,
                                               input logic [C_W-1:0] c);
    logic signed [SUM_W-1:0] ea;
    logic signed [SUM_W-1:0] eb;
    logic        [SUM_W-1:0] ec;
    ea = SUM_W'($signed(a));
    eb = SUM_W'($signed(b));
    ec = SUM_W'(c);
    return ea + (eb <<< B_SHL) + (ec << C_SHL);
  endfunction

endpackage

// File: rtl/abc_add_arb_if.sv
// Requester and result handshake bundle for abc_add_arb.
// Handshake: a transfer happens on a rising edge where valid & ready are both 1;
// the source holds valid and payload stable until that edge, and ready may
// depend combinationally on valid but never the other way round.
interface abc_add_arb_if
  import abc_add_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 2
);

  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_ready;
  logic [A_W*NREQ-1:0] req_a;
  logic [B_W*NREQ-1:0] req_b;
  logic [C_W*NREQ-1:0] req_c;
  logic                res_valid;
  logic                res_ready;
  logic [SUM_W-1:0]    res_sum;
  logic [TAGW-1:0]     res_tag;

  modport master (
    output req_valid, req_a, req_b, req_c, res_ready,
    input  req_ready, res_valid, res_sum, res_tag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_c, res_ready,
    output req_ready, res_valid, res_sum, res_tag
  );

endinterface

// File: rtl/abc_add_rr_pick.sv
// Combinational round-robin picker: first valid requester at or after ptr,
// wrapping modulo NREQ; returns a one-hot grant and its index.
module abc_add_rr_pick
  import abc_add_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic [NREQ-1:0] valid,
  input  logic [TAGW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [TAGW-1:0] idx,
  output logic            any
);

  int j;

  // Walk from the farthest candidate down so the nearest one to ptr wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    j     = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      j = (int'(ptr) + k) % NREQ;
      if (valid[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        idx      = TAGW'(j);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/abc_add_arb.sv
// Round-robin arbiter sharing one three-operand adder among NREQ requesters,
// with a small result FIFO. Optional grant statistics: ABC_ADD_ARB_STATS_EN.
module abc_add_arb
  import abc_add_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int TAGW      = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  abc_add_arb_if.slave    bus,
  output logic [TAGW-1:0] dbg_rr_ptr
`ifdef ABC_ADD_ARB_STATS_EN
  ,
  input  logic [TAGW-1:0] stat_sel,
  output logic [15:0]     stat_cnt
`endif
);

  localparam int PW = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [TAGW-1:0] rr_ptr;
  logic [NREQ-1:0] grant;
  logic [TAGW-1:0] gidx;
  logic            gany;
  logic [CW-1:0]   count;
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  abc_res_t        mem [OUT_DEPTH];
  abc_res_t        head;
  abc_res_t        new_res;
  logic            can_push;
  logic            push;
  logic            pop;
  logic [A_W-1:0]  op_a;
  logic [B_W-1:0]  op_b;
  logic [C_W-1:0]  op_c;

  abc_add_rr_pick #(.NREQ(NREQ), .TAGW(TAGW)) u_pick (
    .valid (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant),
    .idx   (gidx),
    .any   (gany)
  );

  // Ready depends only on the registered count, so a pop never frees a slot
  // for a push in the same cycle and res_ready cannot reach req_ready.
  assign can_push      = !rst && gany && (count < CW'(OUT_DEPTH));
  assign bus.req_ready = can_push ? grant : '0;
  assign push          = |(bus.req_valid & bus.req_ready);
  assign pop           = (count != '0) && bus.res_ready;

  assign op_a = bus.req_a[int'(gidx)*A_W +: A_W];
  assign op_b = bus.req_b[int'(gidx)*B_W +: B_W];
  assign op_c = bus.req_c[int'(gidx)*C_W +: C_W];

  always_comb begin
    new_res     = '0;
    new_res.sum = abc_sum(op_a, op_b, op_c);
    new_res.tag = MAX_TAGW'(gidx);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr <= '0;
      count  <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (gidx == TAGW'(NREQ - 1)) ? '0 : gidx + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_res;
  end

  assign head          = mem[rd_ptr];
  assign bus.res_valid = (count != '0);
  assign bus.res_sum   = bus.res_valid ? head.sum : '0;
  assign bus.res_tag   = bus.res_valid ? TAGW'(head.tag) : '0;
  assign dbg_rr_ptr    = rr_ptr;

`ifdef ABC_ADD_ARB_STATS_EN
  logic [15:0] stat_q [NREQ];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREQ; i++) stat_q[i] <= '0;
    end else if (push) begin
      stat_q[gidx] <= stat_q[gidx] + 16'd1;
    end
  end

  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (TAGW'(i) == stat_sel) stat_cnt = stat_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_abc_add_arb.sv
// Self-checking bench for abc_add_arb: vector table, directed corner
// sequences and randomized traffic against a behavioural queue model.
module tb_abc_add_arb;

  localparam int NREQ      = 4;
  localparam int TAGW      = 2;
  localparam int OUT_DEPTH = 2;
  localparam int RW        = 10 + TAGW;

  logic clk;
  logic rst;
  logic [TAGW-1:0] dbg_rr_ptr;
`ifdef ABC_ADD_ARB_STATS_EN
  logic [TAGW-1:0] stat_sel;
  logic [15:0]     stat_cnt;
`endif

  abc_add_arb_if #(.NREQ(NREQ), .TAGW(TAGW)) bus ();

  abc_add_arb #(.NREQ(NREQ), .TAGW(TAGW), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_rr_ptr (dbg_rr_ptr)
`ifdef ABC_ADD_ARB_STATS_EN
    ,
    .stat_sel   (stat_sel),
    .stat_cnt   (stat_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: values expressed in eighths of a unit
  function automatic logic [9:0] model_sum(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    int ai;
    int bi;
    int eighths;
    ai = a[4] ? int'(a) - 32 : int'(a);
    bi = b[4] ? int'(b) - 32 : int'(b);
    eighths = ai + bi * 4 + int'(c) * 8;
    return 10'(eighths);
  endfunction

  // scoreboard
  logic [RW-1:0]   exp_q[$];
  int              m_rr = 0;
  int              m_stat [NREQ];
  logic [NREQ-1:0] m_acc = '0;
  logic [NREQ-1:0] exp_ready;
  logic [NREQ-1:0] acc;
  logic            found;
  int              gj;
  int              jj;

  initial for (int i = 0; i < NREQ; i++) m_stat[i] = 0;

  always @(negedge clk) begin
    exp_ready = '0;
    found = 1'b0;
    gj = 0;
    if (!rst && exp_q.size() < OUT_DEPTH) begin
      for (int k = 0; k < NREQ; k++) begin
        jj = (m_rr + k) % NREQ;
        if (!found && bus.req_valid[jj]) begin
          found = 1'b1;
          gj = jj;
        end
      end
      if (found) exp_ready[gj] = 1'b1;
    end
    chk("req_ready", 32'(bus.req_ready), 32'(exp_ready));
    acc = '0;
    if (rst) begin
      exp_q.delete();
      m_rr = 0;
      for (int i = 0; i < NREQ; i++) m_stat[i] = 0;
    end else begin
      chk("res_valid", 32'(bus.res_valid), 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("res_head", 32'({bus.res_tag, bus.res_sum}), 32'(exp_q[0]));
      chk("rr_ptr", 32'(dbg_rr_ptr), 32'(m_rr));
`ifdef ABC_ADD_ARB_STATS_EN
      chk("stat_cnt", 32'(stat_cnt), 32'(m_stat[int'(stat_sel)]));
`endif
      acc = bus.req_valid & exp_ready;
      if (exp_q.size() != 0 && bus.res_ready) void'(exp_q.pop_front());
      if (acc != '0) begin
        exp_q.push_back({TAGW'(gj), model_sum(bus.req_a[gj*5 +: 5], bus.req_b[gj*5 +: 5], bus.req_c[gj*5 +: 5])});
        m_rr = (gj + 1) % NREQ;
        m_stat[gj] = (m_stat[gj] + 1) % 65536;
      end
    end
    m_acc = acc;
  end

  // driver tasks
  task automatic set_ops(input int r, input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
    bus.req_a[r*5 +: 5] = a;
    bus.req_b[r*5 +: 5] = b;
    bus.req_c[r*5 +: 5] = c;
  endtask

  task automatic rand_ops(input int r);
    set_ops(r, 5'($urandom), 5'($urandom), 5'($urandom));
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
  endtask

  task automatic apply_one(input int r, input logic [4:0] a, input logic [4:0] b,
                           input logic [4:0] c, input logic [9:0] sum);
    int n;
    logic got;
    next_cycle();
    set_ops(r, a, b, c);
    bus.req_valid[r] = 1'b1;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      got = bus.req_ready[r];
      n++;
    end
    if (!got) chk("accept_timeout", 32'(got), 32'd1);
    next_cycle();
    bus.req_valid[r] = 1'b0;
    @(negedge clk);
    chk("vec_valid", 32'(bus.res_valid), 32'd1);
    chk("vec_sum", 32'(bus.res_sum), 32'(sum));
    chk("vec_tag", 32'(bus.res_tag), 32'(r));
  endtask

  typedef struct {
    int         req;
    logic [4:0] a;
    logic [4:0] b;
    logic [4:0] c;
    logic [9:0] sum;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int n;
    rst = 1'b1;
    bus.req_valid = '0;
    bus.req_a = '0;
    bus.req_b = '0;
    bus.req_c = '0;
    bus.res_ready = 1'b0;
`ifdef ABC_ADD_ARB_STATS_EN
    stat_sel = '0;
`endif
    vecs[0] = '{2, 5'b01000, 5'b00011, 5'd3,  10'd44};
    vecs[1] = '{0, 5'b10000, 5'b10000, 5'd0,  10'h3B0};
    vecs[2] = '{1, 5'b00000, 5'b00000, 5'd0,  10'd0};
    vecs[3] = '{3, 5'b01111, 5'b01111, 5'd31, 10'd323};
    vecs[4] = '{2, 5'b11111, 5'b11111, 5'd1,  10'd3};
    vecs[5] = '{1, 5'b10000, 5'b01111, 5'd31, 10'd292};

    repeat (3) next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_res_valid", 32'(bus.res_valid), 32'd0);
    chk("rst_res_sum", 32'(bus.res_sum), 32'd0);
    chk("rst_res_tag", 32'(bus.res_tag), 32'd0);
    chk("rst_rr_ptr", 32'(dbg_rr_ptr), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);

    bus.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) apply_one(vecs[i].req, vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].sum);

    // fairness: all valid, no backpressure
    do_reset();
    for (int r = 0; r < NREQ; r++) rand_ops(r);
    bus.req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("rr_grant", 32'(bus.req_ready), 32'(1 << (k % NREQ)));
      if (k > 0) chk("rr_tag", 32'(bus.res_tag), 32'((k - 1) % NREQ));
      next_cycle();
      rand_ops(k % NREQ);
    end

    // backpressure: FIFO fills, no push-through on a full pop
    do_reset();
    bus.res_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_ready", 32'(bus.req_ready), (k < 2) ? 32'(1 << k) : 32'd0);
      next_cycle();
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    chk("bp_full_pop_ready", 32'(bus.req_ready), 32'd0);
    chk("bp_head0", 32'(bus.res_tag), 32'd0);
    next_cycle();
    @(negedge clk);
    chk("bp_resume_ready", 32'(bus.req_ready), 32'b0100);
    chk("bp_head1", 32'(bus.res_tag), 32'd1);
    next_cycle();

    // reset with results buffered and requests pending
    bus.res_ready = 1'b0;
    repeat (3) next_cycle();
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ready", 32'(bus.req_ready), 32'd0);
    next_cycle();
    rst = 1'b0;
`ifdef ABC_ADD_ARB_STATS_EN
    stat_sel = 2'd1;
`endif
    @(negedge clk);
    chk("mid_rst_valid", 32'(bus.res_valid), 32'd0);
    chk("mid_rst_rr", 32'(dbg_rr_ptr), 32'd0);
    chk("mid_rst_first_acc", 32'(bus.req_ready), 32'b0001);
`ifdef ABC_ADD_ARB_STATS_EN
    chk("mid_rst_stat", 32'(stat_cnt), 32'd0);
`endif

    // randomized traffic, each requester holds its transaction until accepted
    for (int cyc = 0; cyc < 3000; cyc++) begin
      next_cycle();
      bus.res_ready = ($urandom_range(0, 3) != 0);
`ifdef ABC_ADD_ARB_STATS_EN
      stat_sel = TAGW'($urandom_range(0, NREQ - 1));
`endif
      for (int r = 0; r < NREQ; r++) begin
        if (!bus.req_valid[r] || m_acc[r]) begin
          bus.req_valid[r] = ($urandom_range(0, 1) == 1);
          rand_ops(r);
        end
      end
    end

`ifdef ABC_ADD_ARB_STATS_EN
    // grant counter wrap on requester 1
    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    stat_sel = 2'd1;
    do_reset();
    bus.req_valid = 4'b0010;
    n = 0;
    for (int cyc = 0; cyc < 70000 && n < 65537; cyc++) begin
      next_cycle();
      if (m_acc[1]) n++;
    end
    bus.req_valid = '0;
    chk("wrap_accepts", 32'(n), 32'd65537);
    @(negedge clk);
    chk("wrap_stat", 32'(stat_cnt), 32'd1);
`endif

    bus.req_valid = '0;
    bus.res_ready = 1'b1;
    n = 0;
    repeat (6) next_cycle();
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    chk("drain_valid", 32'(bus.res_valid), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/abc_add_arb.md
# abc_add_arb

Round-robin arbiter and result buffer that shares one three-operand adder datapath among NREQ requesters. Each requester presents an (a, b, c) operand triple with a valid/ready handshake. The arbiter grants one requester per cycle, drives the shared adder, and registers the 10-bit sum with the requester's tag into a small output FIFO. It sits between the operand-producing front ends and any downstream consumer of fixed-point sums.

## Interface
- NREQ, 4: number of requesters; 2..8.
- TAGW, 2: tag width; must satisfy 2^TAGW ≥ NREQ.
- OUT_DEPTH, 2: output FIFO entries; power of two, ≥2.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester operand valid.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_a  in  5*NREQ  slice i = requester i operand a; 2's complement 2.3.
- req_b  in  5*NREQ  slice i = operand b; 2's complement 4.1.
- req_c  in  5*NREQ  slice i = operand c; unsigned 5.0.
- res_valid  out  1  FIFO head valid.
- res_ready  in  1  consumer accept.
- res_sum  out  10  sum; 2's complement 7.3.
- res_tag  out  TAGW  index of the requester that produced res_sum.

## Operation
- Arithmetic: res_sum = sext(a) + (sext(b) << 2) + (c << 3), all in 10 bits. Result range is [-10.0, 40.375], so the sum never overflows 7.3.
- Grant: the first i with req_valid[i], searched from rr_ptr upward modulo NREQ.
- req_ready[grant] = 1 only when fifo_count < OUT_DEPTH and rst = 0. All other bits are 0.
- Accept: req_valid[i] & req_ready[i]. On accept:
  - The adder output and tag i are pushed into the FIFO.
  - rr_ptr ← (i+1) mod NREQ.
- With no accept, rr_ptr holds.
- req_ready may change combinationally with req_valid. A requester must hold its valid and operands stable until accepted.
- FIFO: push on accept, pop on res_valid & res_ready.
  - Simultaneous push and pop keeps the count unchanged and data order preserved.
  - No push-through when full: req_ready is low at count = OUT_DEPTH even if a pop occurs that cycle.
- res_valid = (fifo_count ≠ 0). res_sum and res_tag show the FIFO head and stay stable while res_valid & !res_ready.
- Reset values: rr_ptr = 0, FIFO empty, res_valid = 0, req_ready = 0, res_sum = 0, res_tag = 0. Statistics counters, if present, are also 0.
- Reset mid-operation discards all buffered results. The first accept after reset may occur in the first cycle with rst = 0.

## Timing
- Latency: accept at edge T gives res_valid = 1 after edge T (visible in cycle T+1), provided the FIFO was empty.
- Throughput: one accept per cycle while the consumer keeps res_ready high.
- Fairness: with all NREQ requesters continuously valid and no backpressure, grants rotate 0,1,…,NREQ-1,0,…. Each requester waits at most NREQ-1 accepts.
- No combinational path from res_ready to req_ready.

## Configuration
- ABC_ADD_ARB_STATS_EN defined:
  - Adds stat_sel (in, TAGW) and stat_cnt (out, 16).
  - One 16-bit grant counter per requester, incremented on each accept of that requester.
  - Counters wrap from 16'hFFFF to 0.
  - stat_cnt = counter[stat_sel], combinational read.
  - Counters are cleared by rst.
- ABC_ADD_ARB_STATS_EN undefined: the ports and counters are absent. All other behaviour is identical.

## Structure
- Shared package abc_add_pkg holds:
  - operand widths (A_W = B_W = C_W = 5, SUM_W = 10) and fractional alignment shifts (B_SHL = 2, C_SHL = 3);
  - the result struct {sum, tag}.
- One sub-module, abc_add_rr_pick: combinational round-robin priority picker (valid vector, pointer → one-hot grant plus index).
- The adder and FIFO stay in the top module.

## Test plan
- Single request: requester 2, a = 5'b01000 (1.0), b = 5'b00011 (1.5), c = 3. Expect res_sum = 10'd44 (5.5) and res_tag = 2, one cycle after accept.
- Negative extreme: a = 5'b10000, b = 5'b10000, c = 0. Expect res_sum = 10'h3B0 (-10.0).
- All four requesters valid continuously, res_ready = 1. Expect grant order 0,1,2,3,0 on consecutive cycles and tags matching.
- res_ready = 0 with OUT_DEPTH = 2: two accepts, then req_ready = 0 for all requesters. Raising res_ready pops in order and accepts resume the cycle after count drops below 2.
- rst asserted with 2 results buffered and requests pending. Next cycle res_valid = 0, rr_ptr = 0, and the stats counters (if enabled) read 0.
- Stats enabled: force 65537 accepts on requester 1. Expect stat_cnt for stat_sel = 1 to read 1 (wrap).
